// File: rtl/avl_data_arbiter.sv
// Two-requester Avalon-MM host arbiter: latches data/io start pulses, issues one bus command at a time.
// Optional performance counters are compiled in when AVL_ARB_PERF_EN is defined.
module avl_data_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef AVL_ARB_PERF_EN
    input  logic              perf_clr,
    output logic [31:0]       perf_data_grants,
    output logic [31:0]       perf_io_grants,
    output logic [31:0]       perf_stall,
`endif
    input  logic              data_start,
    input  logic              data_write,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_data_wr,
    output logic              data_ready,
    output logic [DATA_W-1:0] data_data_rd,
    input  logic              io_start,
    input  logic              io_write,
    input  logic [ADDR_W-1:0] io_addr,
    input  logic [DATA_W-1:0] io_data_wr,
    output logic              io_ready,
    output logic [DATA_W-1:0] io_data_rd,
    output logic [31:0]       avl_address,
    output logic              avl_read,
    output logic              avl_write,
    output logic [DATA_W-1:0] avl_writedata,
    input  logic [DATA_W-1:0] avl_readdata,
    input  logic              avl_waitrequest
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, state_next;

    logic              data_pend, io_pend;
    logic              data_wr_q, io_wr_q;
    logic [ADDR_W-1:0] data_addr_q, io_addr_q;
    logic [DATA_W-1:0] data_wdata_q, io_wdata_q;

    // Grant of the transaction in flight; after completion it doubles as the round-robin history.
    logic              gnt_io;
    logic              issue, done, pick_io;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        done       = 1'b0;
        pick_io    = 1'b0;
        case (state)
            IDLE: begin
                if (data_pend || io_pend) begin
                    issue      = 1'b1;
                    state_next = BUSY;
                    if (data_pend && io_pend) begin
                        pick_io = RR ? ~gnt_io : 1'b0;
                    end else begin
                        pick_io = io_pend;
                    end
                end
            end
            BUSY: begin
                if (!avl_waitrequest) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel_wr    = pick_io ? io_wr_q    : data_wr_q;
        sel_addr  = pick_io ? io_addr_q  : data_addr_q;
        sel_wdata = pick_io ? io_wdata_q : data_wdata_q;
    end

    // A start is only taken while the requester has nothing pending or in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_pend    <= 1'b0;
            data_wr_q    <= 1'b0;
            data_addr_q  <= '0;
            data_wdata_q <= '0;
        end else if (data_start && !data_pend) begin
            data_pend    <= 1'b1;
            data_wr_q    <= data_write;
            data_addr_q  <= data_addr;
            data_wdata_q <= data_data_wr;
        end else if (done && !gnt_io) begin
            data_pend    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            io_pend    <= 1'b0;
            io_wr_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
        end else if (io_start && !io_pend) begin
            io_pend    <= 1'b1;
            io_wr_q    <= io_write;
            io_addr_q  <= io_addr;
            io_wdata_q <= io_data_wr;
        end else if (done && gnt_io) begin
            io_pend    <= 1'b0;
        end
    end

    // Bus command is only loaded on a grant, so it stays frozen across waitrequest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            avl_read      <= 1'b0;
            avl_write     <= 1'b0;
            avl_address   <= '0;
            avl_writedata <= '0;
            gnt_io        <= 1'b1;
        end else if (issue) begin
            avl_read      <= ~sel_wr;
            avl_write     <= sel_wr;
            avl_address   <= 32'({sel_addr, 2'b00});
            avl_writedata <= sel_wdata;
            gnt_io        <= pick_io;
        end else if (done) begin
            avl_read      <= 1'b0;
            avl_write     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_ready   <= 1'b0;
            io_ready     <= 1'b0;
            data_data_rd <= '0;
            io_data_rd   <= '0;
        end else begin
            data_ready <= done && !gnt_io;
            io_ready   <= done && gnt_io;
            if (done && !avl_write) begin
                if (gnt_io) begin
                    io_data_rd <= avl_readdata;
                end else begin
                    data_data_rd <= avl_readdata;
                end
            end
        end
    end

`ifdef AVL_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n || perf_clr) begin
            perf_data_grants <= '0;
            perf_io_grants   <= '0;
            perf_stall       <= '0;
        end else begin
            if (issue && !pick_io) begin
                perf_data_grants <= perf_data_grants + 32'd1;
            end
            if (issue && pick_io) begin
                perf_io_grants <= perf_io_grants + 32'd1;
            end
            if (state == BUSY && avl_waitrequest) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avl_data_arbiter.sv
// Scoreboard bench for avl_data_arbiter: transaction-level reference model with timestamps
// decides which request must appear on the bus and which ready/read data must follow.
module tb_avl_data_arbiter;

   localparam int ADDR_W  = 30;
   localparam int DATA_W  = 32;
   localparam bit RR_MODE = 1'b1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic data_start = 1'b0, data_write = 1'b0;
   logic [ADDR_W-1:0] data_addr = '0;
   logic [DATA_W-1:0] data_data_wr = '0;
   logic data_ready;
   logic [DATA_W-1:0] data_data_rd;
   logic io_start = 1'b0, io_write = 1'b0;
   logic [ADDR_W-1:0] io_addr = '0;
   logic [DATA_W-1:0] io_data_wr = '0;
   logic io_ready;
   logic [DATA_W-1:0] io_data_rd;
   logic [31:0] avl_address;
   logic avl_read, avl_write;
   logic [DATA_W-1:0] avl_writedata;
   logic [DATA_W-1:0] avl_readdata = '0;
   logic avl_waitrequest = 1'b0;
`ifdef AVL_ARB_PERF_EN
   logic perf_clr = 1'b0;
   logic [31:0] perf_data_grants, perf_io_grants, perf_stall;
`endif

   avl_data_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RR(RR_MODE)) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef AVL_ARB_PERF_EN
      .perf_clr(perf_clr),
      .perf_data_grants(perf_data_grants),
      .perf_io_grants(perf_io_grants),
      .perf_stall(perf_stall),
`endif
      .data_start(data_start),
      .data_write(data_write),
      .data_addr(data_addr),
      .data_data_wr(data_data_wr),
      .data_ready(data_ready),
      .data_data_rd(data_data_rd),
      .io_start(io_start),
      .io_write(io_write),
      .io_addr(io_addr),
      .io_data_wr(io_data_wr),
      .io_ready(io_ready),
      .io_data_rd(io_data_rd),
      .avl_address(avl_address),
      .avl_read(avl_read),
      .avl_write(avl_write),
      .avl_writedata(avl_writedata),
      .avl_readdata(avl_readdata),
      .avl_waitrequest(avl_waitrequest)
   );

   // 10 ns clock; inputs change 1 ns after the rising edge, checks happen on the falling edge
   always #5 clk = ~clk;

   int edgeCnt = 0;
   always @(posedge clk) edgeCnt++;

   int nVec = 0;
   int nFail = 0;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeCnt);
      end
   endtask

   // Avalon slave: forced stall count per transaction, then random waitrequest
   int stallTarget = 0;
   int waitPct = 0;
   int stallCnt = 0;
   bit fixedRdEn = 1'b0;
   logic [DATA_W-1:0] fixedRd = '0;

   always @(posedge clk) begin
      #1;
      if (avl_read || avl_write) begin
         if (stallCnt < stallTarget) begin
            avl_waitrequest = 1'b1;
            stallCnt++;
         end else begin
            avl_waitrequest = ($urandom_range(99) < waitPct);
         end
      end else begin
         stallCnt = 0;
         avl_waitrequest = $urandom_range(1) == 1;
      end
      avl_readdata = fixedRdEn ? fixedRd : $urandom;
   end

   // Reference model: accepted requests carry the edge at which they were sampled
   typedef struct {
      bit valid;
      bit write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      int acc;
   } req_t;

   typedef struct {
      int who;
      logic [DATA_W-1:0] data;
      int due;
   } rsp_t;

   req_t req[2];
   rsp_t expQ[$];
   bit mBusy = 1'b0;
   int mGnt = 0;
   int mLast = 1;
   bit mWr = 1'b0;
   logic [DATA_W-1:0] mRd[2];
   logic [33:0] snapCmd;
   logic [DATA_W-1:0] snapWdata;
   int grants[2];
   int mStall = 0;
   bit rstAtEdge = 1'b1;
   bit cmpAtEdge = 1'b0;
   logic [DATA_W-1:0] rdAtEdge;

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         req[i].valid = 1'b0;
         mRd[i] = '0;
         grants[i] = 0;
      end
      expQ.delete();
      mBusy = 1'b0;
      mLast = 1;
      mStall = 0;
   endtask

   // Monitor: outputs reflect the last rising edge, inputs are those the next edge will sample
   always @(negedge clk) begin
      bit busyBefore, expectIssue, newCmd;
      bit cand0, cand1;
      int win;
      rsp_t r;
      if (rstAtEdge) begin
         checkOutput("reset_outputs",
                     {56'd0, avl_read, avl_write, data_ready, io_ready,
                      |avl_address, |avl_writedata, |data_data_rd, |io_data_rd}, 64'd0);
         modelReset();
      end else begin
         busyBefore = mBusy;
         if (cmpAtEdge) begin
            r.who = mGnt;
            r.due = edgeCnt;
            r.data = mWr ? mRd[mGnt] : rdAtEdge;
            mRd[mGnt] = r.data;
            expQ.push_back(r);
            req[mGnt].valid = 1'b0;
            mBusy = 1'b0;
            checkOutput("bus_release", {62'd0, avl_read, avl_write}, 64'd0);
         end else if (busyBefore) begin
            checkOutput("cmd_hold", {30'd0, avl_read, avl_write, avl_address}, {30'd0, snapCmd});
            checkOutput("wdata_hold", 64'(avl_writedata), 64'(snapWdata));
         end
         if (!busyBefore) begin
            cand0 = req[0].valid && req[0].acc <= edgeCnt - 1;
            cand1 = req[1].valid && req[1].acc <= edgeCnt - 1;
            expectIssue = cand0 || cand1;
            newCmd = avl_read || avl_write;
            checkOutput("issue", 64'(newCmd), 64'(expectIssue));
            if (expectIssue && newCmd) begin
               if (cand0 && cand1) begin
                  win = RR_MODE ? ((mLast == 1) ? 0 : 1) : 0;
               end else begin
                  win = cand1 ? 1 : 0;
               end
               checkOutput(win == 0 ? "cmd_rw_data" : "cmd_rw_io",
                           {62'd0, avl_read, avl_write}, {62'd0, ~req[win].write, req[win].write});
               checkOutput("cmd_addr", 64'(avl_address), 64'({req[win].addr, 2'b00}));
               checkOutput("cmd_wdata", 64'(avl_writedata), 64'(req[win].wdata));
               mBusy = 1'b1;
               mGnt = win;
               mLast = win;
               mWr = req[win].write;
               snapCmd = {~req[win].write, req[win].write, 32'({req[win].addr, 2'b00})};
               snapWdata = req[win].wdata;
               grants[win]++;
            end
         end
         if (expQ.size() != 0 && expQ[0].due == edgeCnt) begin
            r = expQ.pop_front();
            checkOutput("ready_pulse", {62'd0, data_ready, io_ready},
                        (r.who == 0) ? 64'd2 : 64'd1);
            if (r.who == 0) begin
               checkOutput("data_rd", 64'(data_data_rd), 64'(r.data));
            end else begin
               checkOutput("io_rd", 64'(io_data_rd), 64'(r.data));
            end
         end else begin
            checkOutput("ready_idle", {62'd0, data_ready, io_ready}, 64'd0);
         end
      end
      rstAtEdge = !rst_n;
      cmpAtEdge = 1'b0;
      if (rst_n) begin
         if (mBusy) begin
            cmpAtEdge = !avl_waitrequest;
            rdAtEdge = avl_readdata;
            if (avl_waitrequest) mStall++;
         end
         if (data_start && !req[0].valid) begin
            req[0] = '{1'b1, data_write, data_addr, data_data_wr, edgeCnt + 1};
         end
         if (io_start && !req[1].valid) begin
            req[1] = '{1'b1, io_write, io_addr, io_data_wr, edgeCnt + 1};
         end
      end
   end

   // One cycle of requester activity, entered and left 1 ns after a rising edge
   task automatic applyStimulus(input bit ds, input bit dw, input logic [ADDR_W-1:0] da,
                                input logic [DATA_W-1:0] dd, input bit is, input bit iw,
                                input logic [ADDR_W-1:0] ia, input logic [DATA_W-1:0] id);
      data_start = ds; data_write = dw; data_addr = da; data_data_wr = dd;
      io_start = is; io_write = iw; io_addr = ia; io_data_wr = id;
      @(posedge clk);
      #1;
      data_start = 1'b0;
      io_start = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int g0, g1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // simultaneous reads straight after reset: data must win
      applyStimulus(1, 0, 30'h11, 32'h0, 1, 0, 30'h22, 32'h0);
      idle(10);

      // single read with known read data
      fixedRdEn = 1'b1;
      fixedRd = 32'hDEADBEEF;
      applyStimulus(1, 0, 30'h100, 32'h0, 0, 0, 30'h0, 32'h0);
      idle(6);

      // simultaneous again with data granted last: io goes first
      applyStimulus(1, 1, 30'h33, 32'hCAFE0001, 1, 0, 30'h44, 32'h0);
      idle(10);

      // io write stalled for five cycles
      stallTarget = 5;
      applyStimulus(0, 0, 30'h0, 32'h0, 1, 1, 30'h3000, 32'h12345678);
      idle(12);

      // duplicate data start while the first is still pending
      stallTarget = 3;
      applyStimulus(1, 0, 30'h4, 32'h0, 0, 0, 30'h0, 32'h0);
      applyStimulus(1, 0, 30'h5, 32'h0, 0, 0, 30'h0, 32'h0);
      idle(12);
      stallTarget = 0;
      fixedRdEn = 1'b0;

      // fairness: both requesters always asking, grants must alternate
      waitPct = 30;
      g0 = grants[0];
      g1 = grants[1];
      for (int k = 0; k < 400 && (grants[0] + grants[1] - g0 - g1) < 20; k++) begin
         applyStimulus(1, 1'($urandom_range(1)), 30'($urandom), $urandom,
                       1, 1'($urandom_range(1)), 30'($urandom), $urandom);
      end
      checkOutput("fair_data_grants", 64'(grants[0] - g0), 64'd10);
      checkOutput("fair_io_grants", 64'(grants[1] - g1), 64'd10);
      idle(30);

      // random traffic
      waitPct = 40;
      for (int k = 0; k < 600; k++) begin
         applyStimulus($urandom_range(99) < 30, 1'($urandom_range(1)), 30'($urandom), $urandom,
                       $urandom_range(99) < 30, 1'($urandom_range(1)), 30'($urandom), $urandom);
      end
      waitPct = 0;
      idle(30);

      // reset while a read is stalled, then a clean read
      stallTarget = 20;
      applyStimulus(1, 0, 30'h55, 32'h0, 0, 0, 30'h0, 32'h0);
      for (int k = 0; k < 10 && !avl_read; k++) idle(1);
      checkOutput("busy_before_reset", 64'(avl_read), 64'd1);
      idle(2);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      stallTarget = 0;
      idle(2);
      applyStimulus(0, 0, 30'h0, 32'h0, 1, 0, 30'h66, 32'h0);
      idle(10);

      checkOutput("drained", 64'(expQ.size() + int'(mBusy) + int'(req[0].valid) + int'(req[1].valid)), 64'd0);
`ifdef AVL_ARB_PERF_EN
      checkOutput("perf_data_grants", 64'(perf_data_grants), 64'(grants[0]));
      checkOutput("perf_io_grants", 64'(perf_io_grants), 64'(grants[1]));
      checkOutput("perf_stall", 64'(perf_stall), 64'(mStall));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule
